// File: rtl/riscv_pkg.sv
// Shared RV32 constants for the fetch stage: widths, base opcodes, instruction field positions.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OPC_R_TYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LW      = 7'b0000011;
    localparam logic [6:0] OPC_SW      = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE_I = 7'b0010011;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_W   = 3;
    localparam int unsigned FUNCT7_LSB = 25;
    localparam int unsigned FUNCT7_W   = 7;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding fetched {instruction, pc} pairs; synchronous clear, occupancy output.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; a full FIFO may push over the slot being popped this cycle.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i && !reset) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!(push_i && !pop_i && (count_q == CNT_W'(DEPTH))));
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads with credit-based flow control,
// buffers returned words and presents them to decode with pre-sliced opcode fields.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int unsigned     DEPTH    = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [ILEN-1:0]  imem_rdata,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [ILEN-1:0]  inst,
    output logic [XLEN-1:0]  inst_pc,
    output logic [6:0]       opcode,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned CRD_W = CNT_W + 1;
    localparam int unsigned ENT_W = ILEN + XLEN;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic             outstanding_q, outstanding_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] fifo_count;
    logic [ENT_W-1:0] fifo_rdata;
    logic             fifo_push;
    logic             fifo_pop;
    logic             accept;
    logic [CRD_W-1:0] credits_used;

    assign inst_valid = !reset && (fifo_count != '0);
    assign fifo_pop   = inst_valid && inst_ready;

    // A slot freed by this cycle's pop is reusable immediately; this is what sustains 1 instr/cycle.
    assign credits_used = CRD_W'(fifo_count) + CRD_W'(outstanding_q) - CRD_W'(fifo_pop);
    assign imem_req     = !reset && !redirect_valid && (credits_used < CRD_W'(DEPTH));
    assign accept       = imem_req && imem_ready;
    assign imem_addr    = fetch_pc_q;

    assign fifo_push = imem_rvalid && outstanding_q && !drop_q && !redirect_valid;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (imem_rvalid) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
        end
        if (accept) begin
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
            req_pc_d      = fetch_pc_q;
            outstanding_d = 1'b1;
        end
        // A response still owed after the redirect cycle must be swallowed when it lands.
        if (redirect_valid) begin
            fetch_pc_d    = redirect_pc & ~XLEN'(3);
            outstanding_d = 1'b0;
            drop_d        = !imem_rvalid && (outstanding_q || drop_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // A response with nothing owed is a memory protocol violation.
    always_ff @(posedge clk) begin
        if (!reset) assert (!(imem_rvalid && !outstanding_q && !drop_q));
    end

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (redirect_valid),
        .push_i  (fifo_push),
        .wdata_i ({imem_rdata, req_pc_q}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    assign {inst, inst_pc} = fifo_rdata;
    assign opcode = inst[OPCODE_LSB +: OPCODE_W];
    assign funct3 = inst[FUNCT3_LSB +: FUNCT3_W];
    assign funct7 = inst[FUNCT7_LSB +: FUNCT7_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized run
// checked against an in-order PC-stream model of the fetch stage.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    int unsigned cyc = 0;
    logic [31:0] pop_pc[$];
    logic [31:0] pop_inst[$];
    logic [31:0] acc_addr[$];
    int unsigned first_acc_cyc, first_val_cyc;
    bit          seen_acc, seen_val;

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7)
    );

    always #5 clk = ~clk;

    // Memory contents: word index at every address, one R-type instruction at the top word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hFFFF_FFFC) return 32'h40A3_8533;
        return {2'b00, a[31:2]};
    endfunction

    // Memory: answers every accepted request exactly one cycle later.
    initial begin
        logic        acc;
        logic [31:0] a;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            acc = imem_req && imem_ready;
            a   = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = acc;
            imem_rdata  = acc ? mem_word(a) : 32'h0;
        end
    end

    // Observation log of delivered instructions and accepted requests.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (inst_valid && inst_ready) begin
                pop_pc.push_back(inst_pc);
                pop_inst.push_back(inst);
            end
            if (imem_req && imem_ready) begin
                acc_addr.push_back(imem_addr);
                if (!seen_acc) begin seen_acc = 1'b1; first_acc_cyc = cyc; end
            end
            if (inst_valid && !seen_val) begin seen_val = 1'b1; first_val_cyc = cyc; end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_log();
        pop_pc.delete();
        pop_inst.delete();
        acc_addr.delete();
        seen_acc = 1'b0;
        seen_val = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; imem_ready = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        cycles(3);
        reset = 1'b0;
        clear_log();
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ready = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs: req=%b valid=%b required 0/0", imem_req, inst_valid);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        clear_log();
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC_DEFAULT || inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: req=%b addr=%h valid=%b required 1/%h/0",
                     imem_req, imem_addr, inst_valid, RESET_PC_DEFAULT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        do_reset();
        cycles(16);
        tests_run++;
        if (!seen_acc || !seen_val || (first_val_cyc - first_acc_cyc) != 2) begin
            tests_failed++;
            $display("FAIL stream_latency: got %0d cycles required 2", first_val_cyc - first_acc_cyc);
        end
        tests_run++;
        if (pop_pc.size() != 14) begin
            tests_failed++;
            $display("FAIL stream_rate: got %0d instrs required 14", pop_pc.size());
        end
        for (int i = 0; i < pop_pc.size(); i++) begin
            tests_run++;
            if (pop_pc[i] !== 32'(4 * i) || pop_inst[i] !== 32'(i)) begin
                tests_failed++;
                $display("FAIL stream_seq[%0d]: pc=%h inst=%h required %h/%h", i, pop_pc[i], pop_inst[i], 4 * i, i);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        cycles(6);
        inst_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            tests_run++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || inst !== 32'h4) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h inst=%h required 1/00000010/00000004",
                         j, inst_valid, inst_pc, inst);
            end
            if (j >= 1) begin
                tests_run++;
                if (imem_req !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stall_req[%0d]: req=%b required 0", j, imem_req);
                end
            end
            @(posedge clk); #1;
        end
        inst_ready = 1'b1;
        cycles(8);
        tests_run++;
        if (pop_pc.size() != 12) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d instrs required 12", pop_pc.size());
        end
        for (int i = 0; i < pop_pc.size(); i++) begin
            tests_run++;
            if (pop_pc[i] !== 32'(4 * i) || pop_inst[i] !== 32'(i)) begin
                tests_failed++;
                $display("FAIL stall_seq[%0d]: pc=%h inst=%h required %h/%h", i, pop_pc[i], pop_inst[i], 4 * i, i);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        cycles(6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL redirect_req: req=%b required 0", imem_req);
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        for (int j = 1; j <= 2; j++) begin
            @(negedge clk);
            tests_run++;
            if (inst_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL redirect_bubble[R+%0d]: valid=%b required 0", j, inst_valid);
            end
            @(posedge clk); #1;
        end
        cycles(4);
        tests_run++;
        if (pop_pc.size() != 9) begin
            tests_failed++;
            $display("FAIL redirect_count: got %0d instrs required 9", pop_pc.size());
        end else begin
            tests_run++;
            if (pop_pc[4] !== 32'h10 || pop_pc[5] !== 32'h100 || pop_inst[5] !== 32'h40 || pop_pc[6] !== 32'h104) begin
                tests_failed++;
                $display("FAIL redirect_seq: pcs %h %h %h inst %h required 10 100 104 / 40",
                         pop_pc[4], pop_pc[5], pop_pc[6], pop_inst[5]);
            end
        end
    endtask

    task automatic test_imem_toggle();
        logic        prev_wait;
        logic [31:0] prev_addr;
        prev_wait = 1'b0;
        prev_addr = '0;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            imem_ready = i[0];
            @(negedge clk);
            if (prev_wait) begin
                tests_run++;
                if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    tests_failed++;
                    $display("FAIL toggle_hold[%0d]: req=%b addr=%h required 1/%h", i, imem_req, imem_addr, prev_addr);
                end
            end
            prev_wait = imem_req && !imem_ready;
            prev_addr = imem_addr;
            @(posedge clk); #1;
        end
        imem_ready = 1'b1;
        tests_run++;
        if (acc_addr.size() < 6 || pop_pc.size() < 5) begin
            tests_failed++;
            $display("FAIL toggle_progress: accepts=%0d pops=%0d required >=6/>=5", acc_addr.size(), pop_pc.size());
        end
        for (int k = 0; k < acc_addr.size(); k++) begin
            tests_run++;
            if (acc_addr[k] !== 32'(4 * k)) begin
                tests_failed++;
                $display("FAIL toggle_acc[%0d]: addr=%h required %h", k, acc_addr[k], 4 * k);
            end
        end
        for (int k = 0; k < pop_pc.size(); k++) begin
            tests_run++;
            if (pop_pc[k] !== 32'(4 * k) || pop_inst[k] !== 32'(k)) begin
                tests_failed++;
                $display("FAIL toggle_pop[%0d]: pc=%h inst=%h required %h/%h", k, pop_pc[k], pop_inst[k], 4 * k, k);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycles(4);
        inst_ready = 1'b0;
        cycles(3);
        @(negedge clk);
        tests_run++;
        if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_full: valid=%b req=%b required 1/0", inst_valid, imem_req);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            tests_run++;
            if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL midreset_outputs[%0d]: valid=%b req=%b required 0/0", j, inst_valid, imem_req);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        inst_ready = 1'b1;
        clear_log();
        cycles(6);
        tests_run++;
        if (pop_pc.size() < 3) begin
            tests_failed++;
            $display("FAIL midreset_count: got %0d instrs required >=3", pop_pc.size());
        end else begin
            tests_run++;
            if (pop_pc[0] !== RESET_PC_DEFAULT || pop_inst[0] !== 32'h0 || pop_pc[1] !== 32'h4
                || (first_val_cyc - first_acc_cyc) != 2) begin
                tests_failed++;
                $display("FAIL midreset_restart: pc0=%h inst0=%h pc1=%h lat=%0d required 0/0/4/2",
                         pop_pc[0], pop_inst[0], pop_pc[1], first_val_cyc - first_acc_cyc);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cycles(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        cycles(1);
        redirect_valid = 1'b0;
        clear_log();
        cycles(2);
        @(negedge clk);
        tests_run++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== 32'h40A3_8533) begin
            tests_failed++;
            $display("FAIL wrap_inst: valid=%b pc=%h inst=%h required 1/fffffffc/40a38533", inst_valid, inst_pc, inst);
        end
        tests_run++;
        if (opcode !== OPC_R_TYPE || funct3 !== 3'b000 || funct7 !== 7'b0100000) begin
            tests_failed++;
            $display("FAIL wrap_fields: opcode=%b funct3=%b funct7=%b required 0110011/000/0100000",
                     opcode, funct3, funct7);
        end
        @(posedge clk); #1;
        cycles(2);
        tests_run++;
        if (acc_addr.size() < 2 || pop_pc.size() < 2) begin
            tests_failed++;
            $display("FAIL wrap_count: accepts=%0d pops=%0d required >=2/>=2", acc_addr.size(), pop_pc.size());
        end else begin
            tests_run++;
            if (acc_addr[0] !== 32'hFFFF_FFFC || acc_addr[1] !== 32'h0 || pop_pc[1] !== 32'h0 || pop_inst[1] !== 32'h0) begin
                tests_failed++;
                $display("FAIL wrap_seq: acc %h %h pop pc %h inst %h required fffffffc 0 / 0 0",
                         acc_addr[0], acc_addr[1], pop_pc[1], pop_inst[1]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, exp_acc, prev_addr, tgt, w;
        logic        prev_wait, prev_redir, redir;
        do_reset();
        exp_pc = RESET_PC_DEFAULT;
        exp_acc = RESET_PC_DEFAULT;
        prev_wait = 1'b0;
        prev_redir = 1'b0;
        prev_addr = '0;
        for (int i = 0; i < 400; i++) begin
            imem_ready     = ($urandom % 4) != 0;
            inst_ready     = ($urandom % 3) != 0;
            redir          = ($urandom % 25) == 0;
            redirect_valid = redir;
            redirect_pc    = $urandom;
            tgt            = redirect_pc & 32'hFFFF_FFFC;
            @(negedge clk);
            if (redir) begin
                tests_run++;
                if (imem_req !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rand_redirect_req[%0d]: req=%b required 0", i, imem_req);
                end
            end else if (imem_req) begin
                tests_run++;
                if (imem_addr !== exp_acc) begin
                    tests_failed++;
                    $display("FAIL rand_addr[%0d]: addr=%h required %h", i, imem_addr, exp_acc);
                end
            end
            if (prev_wait && !redir) begin
                tests_run++;
                if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    tests_failed++;
                    $display("FAIL rand_hold[%0d]: req=%b addr=%h required 1/%h", i, imem_req, imem_addr, prev_addr);
                end
            end
            if (prev_redir) begin
                tests_run++;
                if (inst_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rand_bubble[%0d]: valid=%b required 0", i, inst_valid);
                end
            end
            if (inst_valid && inst_ready) begin
                w = mem_word(exp_pc);
                tests_run++;
                if (inst_pc !== exp_pc || inst !== w || opcode !== w[6:0] || funct3 !== w[14:12] || funct7 !== w[31:25]) begin
                    tests_failed++;
                    $display("FAIL rand_pop[%0d]: pc=%h inst=%h required %h/%h", i, inst_pc, inst, exp_pc, w);
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (imem_req && imem_ready) exp_acc = exp_acc + 32'd4;
            if (redir) begin
                exp_pc  = tgt;
                exp_acc = tgt;
            end
            prev_wait  = imem_req && !imem_ready;
            prev_addr  = imem_addr;
            prev_redir = redir;
            @(posedge clk); #1;
        end
        redirect_valid = 1'b0;
        imem_ready = 1'b1;
        inst_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; imem_ready = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        @(posedge clk); #1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_imem_toggle();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
